// File: rtl/contradores_pkg.sv
// rtl/contradores_pkg.sv - shared types and helpers for the T-stage counters
//
// Contents:
//   state_e     : one-shot FSM state (ST_RUN=0, ST_HALT=1)
//   term_value  : terminal count for up-counting, from modulus and width
package contradores_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  // A modulus of zero selects the full 2^w range, so the terminal is all-ones.
  // Callers cast the result back down to their own width.
  function automatic logic [63:0] term_value(input logic [63:0] mod_v, input int unsigned w);
    if (mod_v == 64'd0) begin
      term_value = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    end else begin
      term_value = mod_v - 64'd1;
    end
  endfunction

endpackage

// File: rtl/ff_t_estagio.sv
// rtl/ff_t_estagio.sv - single T flip-flop stage with async clear to a per-bit value
//
// Ports:
//   clk     in  rising-edge clock
//   clr     in  asynchronous clear, active-high, loads rst_val
//   rst_val in  value taken while clr is high
//   t       in  toggle on the next rising edge when 1
//   q       out stage value
//   q_bar   out complement of q
module ff_t_estagio (
  input  logic clk,
  input  logic clr,
  input  logic rst_val,
  input  logic t,
  output logic q,
  output logic q_bar
);

  logic bit_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      bit_q <= rst_val;
    end else if (t) begin
      bit_q <= ~bit_q;
    end
  end

  assign q     = bit_q;
  assign q_bar = ~bit_q;

endmodule

// File: rtl/modulo_contador_t_param.sv
// rtl/modulo_contador_t_param.sv - up/down modulus counter built from T stages
//
// Ports:
//   clk      in  rising-edge clock
//   clr      in  asynchronous reset, active-high
//   en       in  count enable
//   up       in  direction, 1=up 0=down
//   load     in  synchronous parallel load (wins over en)
//   load_val in  value loaded on load
//   mod_val  in  modulus, 0 selects 2^W
//   oneshot  in  1 halts at terminal, 0 wraps
//   q        out count value
//   q_bar    out complement of q
//   tc       out terminal count (combinational)
//   done     out one-shot finished (registered)
module modulo_contador_t_param
  import contradores_pkg::*;
#(
  parameter int            W         = 4,
  parameter logic [W-1:0]  RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] mod_val,
  input  logic         oneshot,
  output logic [W-1:0] q,
  output logic [W-1:0] q_bar,
  output logic         tc,
  output logic         done
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W-1:0] toggle;
  logic [W-1:0] term_up;
  logic         at_term;
  state_e       state_q, state_d;
  logic         done_q, done_d;

  assign term_up = W'(term_value(64'(mod_val), W));

  // Up uses >= so an out-of-range load is treated as terminal and wraps to 0.
  assign at_term = up ? (cnt_q >= term_up) : (cnt_q == '0);

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    done_d  = done_q;
    if (load) begin
      cnt_d   = load_val;
      state_d = ST_RUN;
      done_d  = 1'b0;
    end else if (en && (state_q == ST_RUN)) begin
      if (at_term && oneshot) begin
        state_d = ST_HALT;
        done_d  = 1'b1;
      end else if (up) begin
        cnt_d = at_term ? '0 : (cnt_q + ONE);
      end else begin
        cnt_d = at_term ? term_up : (cnt_q - ONE);
      end
    end
  end

  // Each stage flips exactly the bits that differ between now and next.
  assign toggle = cnt_q ^ cnt_d;

  for (genvar i = 0; i < W; i++) begin : g_stage
    ff_t_estagio u_ff (
      .clk     (clk),
      .clr     (clr),
      .rst_val (RESET_VAL[i]),
      .t       (toggle[i]),
      .q       (cnt_q[i]),
      .q_bar   (q_bar[i])
    );
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_RUN;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign q    = cnt_q;
  assign tc   = en & ~load & (state_q == ST_RUN) & at_term;
  assign done = done_q;

endmodule
